// File: rtl/lfsr_rand_stream_if.sv
// Valid/ready sample stream from lfsr_rand_stream to its consumer.
// The master drives the sample and valid. The slave drives ready.
interface lfsr_rand_stream_if #(
  parameter int OUT_BITS = 8
);
  logic [OUT_BITS-1:0] rand_o;
  logic                rand_valid_o;
  logic                rand_ready_i;

  modport master (output rand_o, output rand_valid_o, input rand_ready_i);
  modport slave  (input rand_o, input rand_valid_o, output rand_ready_i);
endinterface

// File: rtl/lfsr_rand_stream.sv
// Fibonacci-XNOR LFSR sample generator with rejection-sampled range limit and valid/ready output.
// Optional: define RAND_REJECT_CNT_EN to add the saturating 16-bit reject_cnt_o output.
module lfsr_rand_stream #(
  parameter int               WIDTH    = 16,
  parameter int               OUT_BITS = 8,
  parameter logic [WIDTH-1:0] SEED     = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                seed_i,
  input  logic [WIDTH-1:0]    seed_data,
  input  logic [OUT_BITS-1:0] range_i,
  lfsr_rand_stream_if.master  stream_if,
`ifdef RAND_REJECT_CNT_EN
  output logic [15:0]         reject_cnt_o,
`endif
  output logic                busy_o
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_rand_stream: WIDTH must be in 3..32");
  end
  if (OUT_BITS < 1 || OUT_BITS > WIDTH) begin : g_bad_out_bits
    $error("lfsr_rand_stream: OUT_BITS must be in 1..WIDTH");
  end
  if (SEED == {WIDTH{1'b1}}) begin : g_bad_seed
    $error("lfsr_rand_stream: SEED must not be the all-ones lock-up state");
  end

  // Maximal-length XNOR taps (XAPP052); bit n-1 set for tap n.
  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]      TAPS32   = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS32[WIDTH-1:0];
  localparam int               CNT_W    = $clog2(OUT_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_BITS - 1);
  localparam int               HIST_W   = (OUT_BITS > 1) ? OUT_BITS - 1 : 1;

  typedef enum logic [1:0] {IDLE, FILL, VALID} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    lfsr_q, lfsr_d;
  logic [HIST_W-1:0]   sample_q, sample_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OUT_BITS-1:0] rand_q, rand_d;

  logic                next_bit;
  logic [OUT_BITS-1:0] candidate;
  logic [HIST_W-1:0]   sample_shift;
  logic                final_shift;
  logic                cand_ok;

  assign next_bit = ~^(lfsr_q & TAPS);

  // sample_q keeps only the bits already shifted in; next_bit completes the candidate.
  if (OUT_BITS > 1) begin : g_multi_bit
    assign candidate    = {sample_q, next_bit};
    assign sample_shift = candidate[HIST_W-1:0];
  end else begin : g_single_bit
    assign candidate    = next_bit;
    assign sample_shift = '0;
  end

  assign final_shift = (state_q == FILL) && en_i && (cnt_q == LAST_CNT);
  assign cand_ok     = (range_i == '0) || (candidate < range_i);

  always_comb begin
    // NOTE: every next-state value starts from its hold value so no path through
    // the case leaves one unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    sample_d = sample_q;
    cnt_d    = cnt_q;
    rand_d   = rand_q;

    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (en_i) begin
          lfsr_d   = {lfsr_q[WIDTH-2:0], next_bit};
          sample_d = sample_shift;
          if (final_shift) begin
            cnt_d = '0;
            if (cand_ok) begin
              rand_d  = candidate;
              state_d = VALID;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      VALID: begin
        if (stream_if.rand_ready_i) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Seeding overrides everything, including a same-edge accept.
    if (seed_i) begin
      lfsr_d   = (seed_data == {WIDTH{1'b1}}) ? SEED : seed_data;
      state_d  = IDLE;
      cnt_d    = '0;
      sample_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      sample_q <= '0;
      cnt_q    <= '0;
      rand_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      rand_q   <= rand_d;
    end
  end

  assign stream_if.rand_o       = rand_q;
  assign stream_if.rand_valid_o = (state_q == VALID);
  assign busy_o                 = (state_q == FILL);

`ifdef RAND_REJECT_CNT_EN
  logic [15:0] reject_cnt_q;
  logic        rejected;

  assign rejected = final_shift && !cand_ok && !seed_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reject_cnt_q <= '0;
    end else if (seed_i) begin
      reject_cnt_q <= '0;
    end else if (rejected && (reject_cnt_q != 16'hFFFF)) begin
      reject_cnt_q <= reject_cnt_q + 16'd1;
    end
  end

  assign reject_cnt_o = reject_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_rand_stream.sv
// Directed bench for lfsr_rand_stream: 4-bit samples, 1-bit stream and default-parameter instance.
// Expected values are hand-derived from the 4-bit and 16-bit XNOR LFSR sequences starting at 0.
module tb_lfsr_rand_stream;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  // Instance A: WIDTH=4, OUT_BITS=4
  logic       en_a, seed_a, busy_a;
  logic [3:0] seed_data_a, range_a;
  lfsr_rand_stream_if #(.OUT_BITS(4)) if_a ();

  // Instance B: WIDTH=4, OUT_BITS=1
  logic       en_b, seed_b, busy_b;
  logic [3:0] seed_data_b;
  logic [0:0] range_b;
  lfsr_rand_stream_if #(.OUT_BITS(1)) if_b ();

  // Instance C: default parameters
  logic        en_c, seed_c, busy_c;
  logic [15:0] seed_data_c;
  logic [7:0]  range_c;
  lfsr_rand_stream_if #(.OUT_BITS(8)) if_c ();

`ifdef RAND_REJECT_CNT_EN
  logic [15:0] rc_a, rc_b, rc_c;
`endif

  lfsr_rand_stream #(.WIDTH(4), .OUT_BITS(4), .SEED(4'h0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_a), .seed_i(seed_a),
    .seed_data(seed_data_a), .range_i(range_a), .stream_if(if_a),
`ifdef RAND_REJECT_CNT_EN
    .reject_cnt_o(rc_a),
`endif
    .busy_o(busy_a)
  );

  lfsr_rand_stream #(.WIDTH(4), .OUT_BITS(1), .SEED(4'h0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_b), .seed_i(seed_b),
    .seed_data(seed_data_b), .range_i(range_b), .stream_if(if_b),
`ifdef RAND_REJECT_CNT_EN
    .reject_cnt_o(rc_b),
`endif
    .busy_o(busy_b)
  );

  lfsr_rand_stream dut_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_c), .seed_i(seed_c),
    .seed_data(seed_data_c), .range_i(range_c), .stream_if(if_c),
`ifdef RAND_REJECT_CNT_EN
    .reject_cnt_o(rc_c),
`endif
    .busy_o(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!if_a.rand_valid_o && n < 64);
  endtask

  task automatic wait_b(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!if_b.rand_valid_o && n < 64);
  endtask

  initial begin
    int n;
    logic [14:0] exp_bits;
    // nextbit stream of the 4-bit LFSR from 0, first bit in the MSB
    exp_bits = 15'b111011001010000;

    rst_n = 1'b0;
    en_a = 1'b1; seed_a = 1'b0; seed_data_a = '0; range_a = '0; if_a.rand_ready_i = 1'b0;
    en_b = 1'b1; seed_b = 1'b0; seed_data_b = '0; range_b = '0; if_b.rand_ready_i = 1'b0;
    en_c = 1'b1; seed_c = 1'b0; seed_data_c = '0; range_c = '0; if_c.rand_ready_i = 1'b0;

    // Reset state
    #1;
    check("rst_rand", 32'(if_a.rand_o), 32'h0);
    check("rst_valid", 32'(if_a.rand_valid_o), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_lfsr", 32'(dut_a.lfsr_q), 32'h0);
    tick();
    rst_n = 1'b1;

    // Scenario 1/3: first sample 0xE exactly 4 edges after FILL entry, held under back-pressure
    tick();
    check("fill_entry_busy", 32'(busy_a), 32'h1);
    repeat (3) tick();
    check("no_early_valid", 32'(if_a.rand_valid_o), 32'h0);
    tick();
    check("first_valid", 32'(if_a.rand_valid_o), 32'h1);
    check("first_rand", 32'(if_a.rand_o), 32'hE);
    check("first_busy", 32'(busy_a), 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 32'(if_a.rand_valid_o), 32'h1);
      check("hold_rand", 32'(if_a.rand_o), 32'hE);
      check("hold_lfsr", 32'(dut_a.lfsr_q), 32'hE);
    end
    if_a.rand_ready_i = 1'b1;
    tick();
    if_a.rand_ready_i = 1'b0;
    check("accept_drop_valid", 32'(if_a.rand_valid_o), 32'h0);
    check("accept_busy", 32'(busy_a), 32'h1);
    wait_a(n);
    check("second_latency", 32'(n), 32'd4);
    check("second_rand", 32'(if_a.rand_o), 32'hC);

    // Scenario 4: all-ones seed in VALID falls back to SEED and restarts the sequence
    seed_a = 1'b1; seed_data_a = 4'hF;
    tick();
    seed_a = 1'b0;
    check("seed_drop_valid", 32'(if_a.rand_valid_o), 32'h0);
    check("seed_idle_busy", 32'(busy_a), 32'h0);
    check("seed_fallback_lfsr", 32'(dut_a.lfsr_q), 32'h0);
    if_a.rand_ready_i = 1'b1;
    wait_a(n);
    check("reseed_latency", 32'(n), 32'd5);
    check("reseed_rand", 32'(if_a.rand_o), 32'hE);
    wait_a(n);
    if_a.rand_ready_i = 1'b0;
    check("reseed_next_latency", 32'(n), 32'd5);
    check("reseed_next_rand", 32'(if_a.rand_o), 32'hC);

    // Scenario 2: range 13 rejects 0xE, accepts 0xC
    seed_a = 1'b1; seed_data_a = 4'h0; range_a = 4'd13;
    tick();
    seed_a = 1'b0;
    wait_a(n);
    check("range_latency", 32'(n), 32'd9);
    check("range_rand", 32'(if_a.rand_o), 32'hC);
`ifdef RAND_REJECT_CNT_EN
    check("reject_cnt", 32'(rc_a), 32'd1);
`endif

    // Scenario 6: asynchronous reset mid-FILL
    if_a.rand_ready_i = 1'b1;
    tick();
    if_a.rand_ready_i = 1'b0;
    check("pre_rst_rand_held", 32'(if_a.rand_o), 32'hC);
    tick();
    check("pre_rst_busy", 32'(busy_a), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rand", 32'(if_a.rand_o), 32'h0);
    check("async_rst_valid", 32'(if_a.rand_valid_o), 32'h0);
    check("async_rst_busy", 32'(busy_a), 32'h0);
    check("async_rst_lfsr", 32'(dut_a.lfsr_q), 32'h0);
`ifdef RAND_REJECT_CNT_EN
    check("rst_reject_cnt", 32'(rc_a), 32'd0);
`endif
    range_a = '0;
    #2 rst_n = 1'b1;
    wait_a(n);
    check("post_rst_latency", 32'(n), 32'd5);
    check("post_rst_rand", 32'(if_a.rand_o), 32'hE);

    // Simultaneous seed and accept: seed wins; then range 1 accepts only 0
    if_a.rand_ready_i = 1'b1; seed_a = 1'b1; seed_data_a = 4'h5;
    tick();
    seed_a = 1'b0; if_a.rand_ready_i = 1'b0;
    check("seed_accept_valid", 32'(if_a.rand_valid_o), 32'h0);
    check("seed_accept_busy", 32'(busy_a), 32'h0);
    check("seed_accept_lfsr", 32'(dut_a.lfsr_q), 32'h5);
    range_a = 4'd1;
    wait_a(n);
    check("range1_latency", 32'(n), 32'd5);
    check("range1_rand", 32'(if_a.rand_o), 32'h0);

    // Scenario 5: 1-bit stream follows the period-15 LFSR sequence, pause in FILL
    check("b_first_valid", 32'(if_b.rand_valid_o), 32'h1);
    for (int k = 0; k < 30; k++) begin
      if (k > 0) begin
        wait_b(n);
        check("b_latency", 32'(n), (k == 8) ? 32'd1 : 32'd2);
      end
      check("b_bit", 32'(if_b.rand_o), 32'(exp_bits[14 - (k % 15)]));
      if_b.rand_ready_i = 1'b1;
      if (k == 7) begin
        tick();
        check("b_pause_busy", 32'(busy_b), 32'h1);
        en_b = 1'b0;
        for (int p = 0; p < 3; p++) begin
          tick();
          check("b_pause_valid", 32'(if_b.rand_valid_o), 32'h0);
          check("b_pause_hold", 32'(busy_b), 32'h1);
        end
        en_b = 1'b1;
      end
    end

    // Default parameters: first 8-bit sample from SEED 0 is 0xF0
    check("c_valid", 32'(if_c.rand_valid_o), 32'h1);
    check("c_rand", 32'(if_c.rand_o), 32'hF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
